// File: rtl/aes_key_expansion.sv
// AES-128 round-key generator and 11-entry key store with independent encrypt/decrypt pointers.
// Optional: define KEY_EXPANSION_AUTO_EXPAND_EN to expand one round per clock after every key load.
module aes_key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         set_new_key,
    input  logic         start_enc,
    input  logic         ready_enc,
    output logic [127:0] key_enc,
    input  logic         start_dec,
    input  logic         ready_dec,
    output logic [127:0] key_dec,
    output logic         schedule_valid
);

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;
    localparam int unsigned IDX_W      = 4;
    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(NUM_ROUNDS);

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] round_f(input logic [KEY_W-1:0] prev,
                                                 input logic [7:0]       rc);
        logic [WORD_W-1:0] w3, t, n0, n1, n2, n3;
        w3 = prev[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n0 = prev[127:96] ^ t;
        n1 = prev[95:64]  ^ n0;
        n2 = prev[63:32]  ^ n1;
        n3 = w3           ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [KEY_W-1:0] rk_q [NUM_KEYS];
    logic [KEY_W-1:0] rk_d [NUM_KEYS];
    logic [IDX_W-1:0] enc_ptr_q, enc_ptr_d;
    logic [IDX_W-1:0] dec_ptr_q, dec_ptr_d;
    logic [IDX_W-1:0] gen_idx_q, gen_idx_d;
    logic             ready_enc_q, ready_dec_q;
    logic [KEY_W-1:0] key_enc_q, key_enc_d;
    logic [KEY_W-1:0] key_dec_q, key_dec_d;
    logic             schedule_valid_q, schedule_valid_d;

    logic             enc_rise_c, dec_rise_c, gen_fire_c, auto_go_c;
    logic [IDX_W-1:0] gen_next_c, enc_next_c, dec_prev_c;
    logic [KEY_W-1:0] new_rk_c;

    // Single generator: next round key from the highest one generated so far
    always_comb begin
        enc_rise_c = ready_enc & ~ready_enc_q;
        dec_rise_c = ready_dec & ~ready_dec_q;
        gen_next_c = gen_idx_q + IDX_W'(1);
        enc_next_c = enc_ptr_q + IDX_W'(1);
        dec_prev_c = dec_ptr_q - IDX_W'(1);
        new_rk_c   = round_f(rk_q[gen_idx_q], rcon(gen_next_c));
        gen_fire_c = ~set_new_key && (gen_idx_q < LAST_ROUND) &&
                     (auto_go_c || (~start_enc && enc_rise_c && (enc_ptr_q == gen_idx_q)));
    end

`ifdef KEY_EXPANSION_AUTO_EXPAND_EN
    logic auto_run_q, auto_run_d;

    always_comb begin
        auto_run_d = auto_run_q;
        if (set_new_key) begin
            auto_run_d = 1'b1;
        end else if (gen_fire_c && (gen_next_c == LAST_ROUND)) begin
            auto_run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) auto_run_q <= 1'b0;
        else     auto_run_q <= auto_run_d;
    end

    assign auto_go_c = auto_run_q;
`else
    assign auto_go_c = 1'b0;
`endif

    // Key store and generation index
    always_comb begin
        rk_d             = rk_q;
        gen_idx_d        = gen_idx_q;
        schedule_valid_d = schedule_valid_q;
        if (set_new_key) begin
            rk_d[0]          = key_in;
            gen_idx_d        = '0;
            schedule_valid_d = 1'b0;
        end else if (gen_fire_c) begin
            for (int i = 1; i < NUM_KEYS; i++) begin
                if (gen_next_c == IDX_W'(i)) rk_d[i] = new_rk_c;
            end
            gen_idx_d = gen_next_c;
            if (gen_next_c == LAST_ROUND) schedule_valid_d = 1'b1;
        end
    end

    // Encryption pointer; a step at the generation frontier takes the freshly computed key
    always_comb begin
        enc_ptr_d = enc_ptr_q;
        key_enc_d = key_enc_q;
        if (set_new_key) begin
            enc_ptr_d = '0;
            key_enc_d = key_in;
        end else if (start_enc) begin
            enc_ptr_d = '0;
            key_enc_d = rk_q[0];
        end else if (enc_rise_c && (enc_ptr_q < LAST_ROUND)) begin
            enc_ptr_d = enc_next_c;
            key_enc_d = (enc_ptr_q == gen_idx_q) ? new_rk_c : rk_q[enc_next_c];
        end
    end

    // Decryption pointer walks stored keys only once the schedule is complete
    always_comb begin
        dec_ptr_d = dec_ptr_q;
        key_dec_d = key_dec_q;
        if (set_new_key) begin
            dec_ptr_d = '0;
            key_dec_d = '0;
        end else if (start_dec) begin
            if (schedule_valid_q) begin
                dec_ptr_d = LAST_ROUND;
                key_dec_d = rk_q[NUM_ROUNDS];
            end
        end else if (dec_rise_c && schedule_valid_q && (dec_ptr_q != '0)) begin
            dec_ptr_d = dec_prev_c;
            key_dec_d = rk_q[dec_prev_c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) rk_q[i] <= '0;
            enc_ptr_q        <= '0;
            dec_ptr_q        <= '0;
            gen_idx_q        <= '0;
            ready_enc_q      <= 1'b0;
            ready_dec_q      <= 1'b0;
            key_enc_q        <= '0;
            key_dec_q        <= '0;
            schedule_valid_q <= 1'b0;
        end else begin
            rk_q             <= rk_d;
            enc_ptr_q        <= enc_ptr_d;
            dec_ptr_q        <= dec_ptr_d;
            gen_idx_q        <= gen_idx_d;
            ready_enc_q      <= ready_enc;
            ready_dec_q      <= ready_dec;
            key_enc_q        <= key_enc_d;
            key_dec_q        <= key_dec_d;
            schedule_valid_q <= schedule_valid_d;
        end
    end

    assign key_enc        = key_enc_q;
    assign key_dec        = key_dec_q;
    assign schedule_valid = schedule_valid_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed scoreboard bench for aes_key_expansion (default build, on-demand expansion).
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         set_new_key, start_enc, ready_enc, start_dec, ready_dec;
    logic [127:0] key_enc, key_dec;
    logic         schedule_valid;

    always #5 clk = ~clk;

    aes_key_expansion dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .set_new_key    (set_new_key),
        .start_enc      (start_enc),
        .ready_enc      (ready_enc),
        .key_enc        (key_enc),
        .start_dec      (start_dec),
        .ready_dec      (ready_dec),
        .key_dec        (key_dec),
        .schedule_valid (schedule_valid)
    );

    // FIPS-197 key-expansion example: round keys 0..10
    localparam logic [127:0] KA [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] KB0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KB1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KB10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        string        tag;
        int           sel;
        logic [127:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic push_exp(input string tag, input int sel, input logic [127:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic push_enc(input string tag, input logic [127:0] v);
        push_exp(tag, 0, v);
    endtask

    task automatic push_dec(input string tag, input logic [127:0] v);
        push_exp(tag, 1, v);
    endtask

    task automatic push_sv(input string tag, input logic v);
        push_exp(tag, 2, {127'b0, v});
    endtask

    // Advance one clock, then compare everything queued against the registered outputs
    task automatic cycle();
        exp_t         e;
        logic [127:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0:       obs = key_enc;
                1:       obs = key_dec;
                default: obs = {127'b0, schedule_valid};
            endcase
            n_checks++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic enc_step();
        ready_enc = 1'b1;
        cycle();
        ready_enc = 1'b0;
        cycle();
    endtask

    task automatic dec_step();
        ready_dec = 1'b1;
        cycle();
        ready_dec = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        key_in = '0;
        set_new_key = 1'b0;
        start_enc = 1'b0;
        ready_enc = 1'b0;
        start_dec = 1'b0;
        ready_dec = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        push_enc("rst_enc", '0);
        push_dec("rst_dec", '0);
        push_sv("rst_sv", 1'b0);
        cycle();

        key_in = KA[0];
        set_new_key = 1'b1;
        push_enc("load_enc", KA[0]);
        push_sv("load_sv", 1'b0);
        cycle();
        set_new_key = 1'b0;

        start_dec = 1'b1;
        push_dec("dec_guard", '0);
        cycle();
        start_dec = 1'b0;

        for (int i = 1; i <= 10; i++) begin
            push_enc($sformatf("enc_step%0d", i), KA[i]);
            if (i == 9)  push_sv("sv_pre_full", 1'b0);
            if (i == 10) push_sv("sv_full", 1'b1);
            enc_step();
        end
        push_enc("enc_sat", KA[10]);
        enc_step();

        start_dec = 1'b1;
        push_dec("start_dec", KA[10]);
        cycle();
        start_dec = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            push_dec($sformatf("dec_step%0d", i), KA[10-i]);
            dec_step();
        end
        push_dec("dec_sat", KA[0]);
        dec_step();

        start_enc = 1'b1;
        push_enc("replay_start", KA[0]);
        push_sv("replay_sv", 1'b1);
        cycle();
        start_enc = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_enc($sformatf("replay_step%0d", i), KA[i]);
            enc_step();
        end

        ready_enc = 1'b1;
        repeat (20) cycle();
        ready_enc = 1'b0;
        push_enc("enc_hold_one", KA[6]);
        cycle();

        start_enc = 1'b1;
        ready_enc = 1'b1;
        push_enc("enc_collide", KA[0]);
        cycle();
        start_enc = 1'b0;
        push_enc("enc_collide_hold", KA[0]);
        cycle();
        ready_enc = 1'b0;
        cycle();
        push_enc("after_collide", KA[1]);
        enc_step();

        start_dec = 1'b1;
        cycle();
        start_dec = 1'b0;
        ready_dec = 1'b1;
        repeat (20) cycle();
        ready_dec = 1'b0;
        push_dec("dec_hold_one", KA[9]);
        cycle();

        rst = 1'b1;
        push_enc("midrst_enc", '0);
        push_dec("midrst_dec", '0);
        push_sv("midrst_sv", 1'b0);
        cycle();
        rst = 1'b0;
        push_dec("dec_after_rst", '0);
        dec_step();

        key_in = KB0;
        set_new_key = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_enc($sformatf("loadb_hold%0d", i), KB0);
            push_sv($sformatf("loadb_sv%0d", i), 1'b0);
            cycle();
        end
        set_new_key = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 1)  push_enc("kb_step1", KB1);
            if (i == 10) begin
                push_enc("kb_step10", KB10);
                push_sv("kb_sv", 1'b1);
            end
            enc_step();
        end
        start_dec = 1'b1;
        push_dec("kb_start_dec", KB10);
        cycle();
        start_dec = 1'b0;

        key_in = KA[0];
        set_new_key = 1'b1;
        push_enc("reload_enc", KA[0]);
        push_dec("reload_dec", '0);
        push_sv("reload_sv", 1'b0);
        cycle();
        set_new_key = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
